product_bcd_converter: RTL and testbench
========================================

// Module: product_bcd_converter
// PURPOSE
// - Downstream stage of the 4x4 array multiplier: takes its 8-bit binary product, converts it to packed BCD
//   by sequential double-dabble (shift-and-add-3), and presents the digits for display/readout.
// - One conversion in flight; valid/ready handshake on both sides; IN_W cycles per conversion plus handshake.
// PARAMETERS
// - IN_W    default 8   width of binary input (multiplier product width)
// - DIGITS  default 3   BCD output digits; must satisfy 10**DIGITS > 2**IN_W - 1 (elaboration-time $error if not)
// PORTS
// - clk        in   1           single clock, all state updates on rising edge
// - rst        in   1           synchronous, active-high reset
// - in_valid   in   1           in_data holds a product to convert
// - in_ready   out  1           converter can accept; high only in IDLE
// - in_data    in   IN_W        unsigned binary product (p[7:0] of multiplier)
// - out_valid  out  1           out_bcd holds a completed conversion
// - out_ready  in   1           consumer accepts out_bcd
// - out_bcd    out  4*DIGITS    packed BCD, digit 0 (units) in [3:0], most significant digit in top nibble
// - busy       out  1           high in SHIFT or DONE
// BEHAVIOUR
// - Reset (rst=1 at an edge): state<=IDLE, shift/digit regs<=0, count<=0; in_ready=1, out_valid=0,
//   out_bcd=0, busy=0 from the following cycle. Reset mid-conversion or in DONE aborts; result discarded.
// - FSM states IDLE, SHIFT, DONE; all outputs decoded from registered state/data (no comb in->out paths).
// - IDLE: in_ready=1. On in_valid&&in_ready edge: bin<=in_data, bcd<=0, count<=IN_W, state<=SHIFT.
// - SHIFT: each edge: every digit >=5 gets +3 (4-bit result, digits 0..4 unchanged), then {bcd,bin} shifted
//   left 1 (bin MSB enters bcd LSB, 0 enters bin LSB); count<=count-1; on the edge where count==1
//   state<=DONE. Exactly IN_W shift edges.
// - Latency: acceptance at edge E0 -> out_valid high from the cycle after edge E0+IN_W (8 cycles default).
// - DONE: out_valid=1, out_bcd stable and equal to final bcd. Hold indefinitely while out_ready=0.
//   On out_valid&&out_ready edge: state<=IDLE; in_ready=1 the next cycle (no same-cycle accept in DONE).
// - out_bcd retains last result after handshake until next acceptance clears bcd (out_valid=0 meanwhile).
// - in_valid while busy: ignored, in_data not sampled; upstream must hold until in_ready.
// - out_ready while not out_valid: ignored. Throughput: one result per IN_W+2 cycles with zero backpressure.
// - Arithmetic: unsigned only; max input 2**IN_W-1 (255 default -> 0x255); no overflow possible given check.
// STRUCTURE
// - Package product_bcd_pkg: state enum {IDLE,SHIFT,DONE} (2-bit), BCD_DIGIT_W=4, ADJ_THRESH=5, ADJ_ADD=3,
//   function computing required digit count for a width (used by the parameter check).
// - Sub-module bcd_digit_adj: combinational 4-bit in -> 4-bit out (+3 if >=5), instantiated DIGITS times
//   via generate inside the SHIFT datapath.
// - Top: FSM, count register ($clog2(IN_W+1) bits), bin register IN_W, bcd register 4*DIGITS.
// TESTING
// - in_data=0x00, out_ready=1 -> out_bcd=12'h000, out_valid exactly 8 cycles after accept, 1 cycle wide.
// - in_data=225 (15x15 max product) -> out_bcd=12'h225; in_data=99 -> 12'h099; 100 -> 12'h100; 255 -> 12'h255.
// - Backpressure: 42 converted, out_ready=0 for 5 cycles -> out_valid and out_bcd=12'h042 held; in_ready=0
//   throughout; out_ready=1 -> IDLE next cycle.
// - in_valid with in_data=7 asserted during SHIFT of 200 -> ignored; result 12'h200; 7 accepted after in_ready.
// - rst=1 at 4th SHIFT cycle of 150 -> next cycle in_ready=1, out_valid=0, out_bcd=0; new input 36 -> 12'h036.
// - Exhaustive: all 256 inputs back-to-back with random out_ready stalls -> each out_bcd matches reference model.

Source files
------------

// File: rtl/product_bcd_converter_pkg.sv
// Shared definitions for the product-to-BCD converter.
//   - state_e           : converter FSM states (2-bit encoding)
//   - BCD_DIGIT_W       : width of one packed BCD digit
//   - ADJ_THRESH/ADD    : double-dabble pre-shift correction (digit >= 5 gets +3)
//   - digits_for_width  : decimal digits needed to represent 2**width - 1
package product_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int BCD_DIGIT_W = 4;
  localparam int ADJ_THRESH  = 5;
  localparam int ADJ_ADD     = 3;

  // Number of decimal digits in the largest unsigned value of the given width.
  function automatic int digits_for_width(input int width);
    longint unsigned max_val;
    int              n;
    max_val = (64'd1 << width) - 64'd1;
    n       = 1;
    while (max_val >= 64'd10) begin
      max_val = max_val / 64'd10;
      n       = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/product_bcd_converter_bcd_digit_adj.sv
// Single-digit double-dabble correction.
//   digit_in  : 4-bit BCD digit before the shift
//   digit_out : digit_in + 3 when digit_in >= 5, otherwise digit_in (4-bit result)
module bcd_digit_adj
  import product_bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_in,
  output logic [BCD_DIGIT_W-1:0] digit_out
);

  // Add-3 correction so the following left shift carries correctly into the next digit.
  always_comb begin
    if (digit_in >= BCD_DIGIT_W'(ADJ_THRESH)) begin
      digit_out = digit_in + BCD_DIGIT_W'(ADJ_ADD);
    end else begin
      digit_out = digit_in;
    end
  end

endmodule

// File: rtl/product_bcd_converter.sv
// Sequential binary-to-packed-BCD converter (double dabble) for the multiplier product.
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   in_valid   : in_data holds a product to convert
//   in_ready   : converter idle and able to accept (registered)
//   in_data    : unsigned binary input, IN_W bits
//   out_valid  : out_bcd holds a completed conversion (registered)
//   out_ready  : consumer accepts out_bcd
//   out_bcd    : packed BCD, units digit in [3:0]
//   busy       : conversion in progress or result waiting (registered)
module product_bcd_converter
  import product_bcd_pkg::*;
#(
  parameter int IN_W   = 8,
  parameter int DIGITS = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [IN_W-1:0]             in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd,
  output logic                        busy
);

  localparam int CNT_W = $clog2(IN_W + 1);
  localparam int BCD_W = BCD_DIGIT_W * DIGITS;

  // Too few digits would silently truncate the largest input.
  if (DIGITS < digits_for_width(IN_W)) begin : g_bad_digits
    $error("product_bcd_converter: DIGITS=%0d cannot hold 2**%0d-1", DIGITS, IN_W);
  end

  state_e             state_q, state_d;
  logic [IN_W-1:0]    bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic [BCD_W-1:0]   bcd_adj_s;

  // Per-digit add-3 correction applied to the current BCD accumulator.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_in  (bcd_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_out (bcd_adj_s[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Next-state and datapath computation for the converter FSM.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          bin_d   = in_data;
          bcd_d   = '0;
          count_d = CNT_W'(IN_W);
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        // Binary MSB moves into the BCD LSB; a zero fills the binary LSB.
        {bcd_d, bin_d} = {bcd_adj_s, bin_q} << 1;
        count_d        = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Outputs are registered from the next state so they never depend combinationally on inputs.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d == SHIFT) || (state_d == DONE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bin_q       <= '0;
      bcd_q       <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_bcd   = bcd_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_product_bcd_converter.sv
// Directed plus exhaustive bench for product_bcd_converter with a queue scoreboard.
module tb_product_bcd_converter;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_bcd;
  logic        busy;

  int          n_checks;
  int          n_fails;
  logic [11:0] exp_q[$];
  int          lat;

  product_bcd_converter #(.IN_W(8), .DIGITS(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decimal digits by repeated division.
  function automatic logic [11:0] ref_bcd(input int v);
    logic [11:0] r;
    r = 12'h000;
    for (int i = 0; i < 3; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present v, wait (bounded) for acceptance, push the expected result.
  // Returns at the falling edge right after the accepting rising edge.
  task automatic send(input int v);
    int w;
    in_valid = 1'b1;
    in_data  = 8'(v);
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("accept_timeout", 32'(w < 100), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    exp_q.push_back(ref_bcd(v));
    chk("busy_after_accept", {30'd0, in_ready, busy}, 32'b01);
  endtask

  // Wait (bounded) for out_valid, compare, optionally stall, then complete the handshake.
  task automatic receive(input int stall, output int cycles);
    logic [11:0] exp;
    exp       = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hFFF;
    out_ready = (stall == 0);
    cycles    = 0;
    while (!out_valid && cycles < 50) begin
      @(negedge clk);
      cycles++;
    end
    chk("result_timeout", 32'(cycles < 50), 32'd1);
    chk("out_bcd", 32'(out_bcd), 32'(exp));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("hold_state", {29'd0, out_valid, in_ready, busy}, 32'b101);
      chk("hold_bcd", 32'(out_bcd), 32'(exp));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("after_handshake", {29'd0, out_valid, in_ready, busy}, 32'b010);
    chk("bcd_retained", 32'(out_bcd), 32'(exp));
  endtask

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_flags", {29'd0, in_ready, out_valid, busy}, 32'b100);
    chk("reset_bcd", 32'(out_bcd), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Zero input: 8-cycle latency and single-cycle out_valid with out_ready held high.
    send(0);
    receive(0, lat);
    chk("latency", 32'(lat), 32'd8);

    // Directed values.
    send(225); receive(0, lat);
    send(99);  receive(0, lat);
    send(100); receive(0, lat);
    send(255); receive(0, lat);

    // Backpressure: result held for 5 stalled cycles.
    send(42);  receive(5, lat);

    // in_valid with 7 raised during the conversion of 200 must be ignored.
    send(200);
    in_valid = 1'b1;
    in_data  = 8'd7;
    repeat (3) @(negedge clk);
    chk("ignored_while_busy", {31'd0, in_ready}, 32'd0);
    receive(0, lat);
    send(7);
    receive(0, lat);

    // Reset during the 4th shift cycle of 150 aborts the conversion.
    send(150);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(exp_q.pop_back());
    chk("abort_flags", {29'd0, in_ready, out_valid, busy}, 32'b100);
    chk("abort_bcd", 32'(out_bcd), 32'd0);
    send(36);
    receive(0, lat);

    // Exhaustive sweep with random consumer stalls.
    for (int v = 0; v < 256; v++) begin
      send(v);
      receive(int'($urandom_range(0, 3)), lat);
    end

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
